// File: rtl/fp_mult_pkg.sv
// Shared types and widths for the FP multiplier result path.
// Status bit positions match the multiplier's registered flags.
package fp_mult_pkg;

  localparam int FP_W  = 32;
  localparam int ST_W  = 8;
  localparam int LVL_W = 5;

  typedef enum logic [2:0] {
    RND_NE = 3'd0,
    RND_TZ = 3'd1,
    RND_UP = 3'd2,
    RND_DN = 3'd3,
    RND_MM = 3'd4
  } round_values;

  localparam int ST_ZERO    = 0;
  localparam int ST_INF     = 1;
  localparam int ST_NAN     = 2;
  localparam int ST_TINY    = 3;
  localparam int ST_HUGE    = 4;
  localparam int ST_INEXACT = 5;

endpackage

// File: rtl/fp_mult_result_buf_if.sv
// Producer/consumer handshake bundle around the result buffer.
// master = testbench/neighbour side, slave = buffer side.
interface fp_mult_result_buf_if;
  import fp_mult_pkg::*;

  logic            in_valid;
  logic [FP_W-1:0] in_z;
  logic [ST_W-1:0] in_status;
  logic            in_ready;
  logic            out_valid;
  logic [FP_W-1:0] out_z;
  logic [ST_W-1:0] out_status;
  logic            out_ready;

  modport master (
    output in_valid, in_z, in_status, out_ready,
    input  in_ready, out_valid, out_z, out_status
  );

  modport slave (
    input  in_valid, in_z, in_status, out_ready,
    output in_ready, out_valid, out_z, out_status
  );

endinterface

// File: rtl/fp_sync_fifo.sv
// Single-clock FIFO: storage, wrapping pointers and fill level.
// Caller guarantees no push when full and no pop when empty.
module fp_sync_fifo
  import fp_mult_pkg::*;
#(
  parameter int W     = 40,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [W-1:0]     wdata_i,
  output logic [W-1:0]     rdata_o,
  output logic [LVL_W-1:0] level_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    if (push_i) wr_d = wr_q + AW'(1);
    if (pop_i)  rd_d = rd_q + AW'(1);
    unique case ({push_i, pop_i})
      2'b10:   lvl_d = lvl_q + LVL_W'(1);
      2'b01:   lvl_d = lvl_q - LVL_W'(1);
      default: lvl_d = lvl_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
    end
  end

  // Storage is not reset; level gates its visibility.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q];
  assign level_o = lvl_q;

endmodule

// File: rtl/fp_mult_result_buf.sv
// Result buffer behind the FP multiplier with status accumulator.
// Define FP_RESULT_DROP_CNT_EN to build the saturating drop counter.
module fp_mult_result_buf
  import fp_mult_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  fp_mult_result_buf_if.slave bus,
  input  logic                clr_acc,
  output logic [ST_W-1:0]     acc_status,
  output logic [LVL_W-1:0]    level,
  output logic [7:0]          drop_cnt
);

  localparam int EW = FP_W + ST_W;

  logic          in_ready;
  logic          out_valid;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;
  logic [ST_W-1:0] acc_q, acc_d;

  assign in_ready  = (level < LVL_W'(DEPTH));
  assign out_valid = (level != '0);
  assign push      = bus.in_valid && in_ready;
  assign pop       = out_valid && bus.out_ready;

  fp_sync_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({bus.in_z, bus.in_status}),
    .rdata_o (head),
    .level_o (level)
  );

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_z      = out_valid ? head[EW-1:ST_W] : '0;
  assign bus.out_status = out_valid ? head[ST_W-1:0] : '0;

  // Clear wins over history, but the same-cycle push still lands.
  always_comb begin
    acc_d = clr_acc ? '0 : acc_q;
    if (push) acc_d = acc_d | bus.in_status;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) acc_q <= '0;
    else      acc_q <= acc_d;
  end

  assign acc_status = acc_q;

`ifdef FP_RESULT_DROP_CNT_EN
  logic [7:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (bus.in_valid && !in_ready && drop_q != 8'hFF)
      drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_q <= '0;
    else      drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_fp_mult_result_buf.sv
// Self-checking bench for fp_mult_result_buf: queue model plus
// directed vectors for latency, full/drop, accumulator and reset.
module tb_fp_mult_result_buf;
  import fp_mult_pkg::*;

  localparam int DEPTH = 4;
`ifdef FP_RESULT_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             clr_acc;
  logic [ST_W-1:0]  acc_status;
  logic [LVL_W-1:0] level;
  logic [7:0]       drop_cnt;

  fp_mult_result_buf_if bus();

  fp_mult_result_buf #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .clr_acc    (clr_acc),
    .acc_status (acc_status),
    .level      (level),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Behavioural model: a queue of {z,status} entries.
  logic [39:0] mq[$];
  logic [7:0]  macc;
  int          mdrop;
  int          mn;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      macc  = 8'h00;
      mdrop = 0;
    end else begin
      mn = mq.size();
      if (DROP_EN && bus.in_valid && mn >= DEPTH && mdrop < 255)
        mdrop++;
      if (clr_acc) macc = 8'h00;
      if (bus.in_valid && mn < DEPTH) macc |= bus.in_status;
      if (bus.out_ready && mn > 0) void'(mq.pop_front());
      if (bus.in_valid && mn < DEPTH)
        mq.push_back({bus.in_z, bus.in_status});
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("m_level", 32'(level), 32'(mq.size()));
      chk("m_in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
      chk("m_out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
      chk("m_out_z", bus.out_z,
          mq.size() != 0 ? mq[0][39:8] : 32'h0);
      chk("m_out_status", 32'(bus.out_status),
          mq.size() != 0 ? 32'(mq[0][7:0]) : 32'h0);
      chk("m_acc", 32'(acc_status), 32'(macc));
      chk("m_drop", 32'(drop_cnt), 32'(mdrop));
    end
  end

  task automatic drv(input logic v, input logic [31:0] z,
                     input logic [7:0] s, input logic r,
                     input logic c);
    bus.in_valid  = v;
    bus.in_z      = z;
    bus.in_status = s;
    bus.out_ready = r;
    clr_acc       = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    drv(1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_z", bus.out_z, 32'h0);
    chk("rst_level", 32'(level), 32'd0);
    repeat (2) step();
    rst = 1'b1;

    // Single entry latency
    drv(1'b1, 32'h3F800000, 8'h00, 1'b1, 1'b0);
    step();
    chk("lat_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_z", bus.out_z, 32'h3F800000);
    chk("lat_level", 32'(level), 32'd1);
    drv(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
    step();
    chk("lat_level0", 32'(level), 32'd0);

    // Fill and overflow
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, 32'h40000000 + i, 8'h00, 1'b0, 1'b0);
      step();
      if (i == 3) chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    end
    chk("full_level", 32'(level), 32'd4);
    chk("full_drop", 32'(drop_cnt), DROP_EN ? 32'd1 : 32'd0);
    chk("full_head", bus.out_z, 32'h40000000);

    // Full with push and pop: only the pop happens
    drv(1'b1, 32'h99999999, 8'h00, 1'b1, 1'b0);
    step();
    chk("fp_level", 32'(level), 32'd3);
    chk("fp_drop", 32'(drop_cnt), DROP_EN ? 32'd2 : 32'd0);
    for (int i = 1; i < 4; i++) begin
      drv(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
      chk("order_z", bus.out_z, 32'h40000000 + i);
      step();
    end
    chk("drain_level", 32'(level), 32'd0);

    // Status accumulator
    drv(1'b1, 32'h3F000000, 8'h20, 1'b0, 1'b0);
    step();
    drv(1'b1, 32'h3E000000, 8'h04, 1'b0, 1'b0);
    step();
    chk("acc_or", 32'(acc_status), 32'h24);
    drv(1'b1, 32'h3D000000, 8'h02, 1'b0, 1'b1);
    step();
    chk("acc_clr_push", 32'(acc_status), 32'h02);
    chk("acc_level", 32'(level), 32'd3);
    chk("acc_head_st", 32'(bus.out_status), 32'h20);

    // Saturating drops
    drv(1'b1, 32'h3C000000, 8'h10, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 300; i++) step();
    chk("sat_drop", 32'(drop_cnt), DROP_EN ? 32'hFF : 32'h0);
    chk("sat_acc", 32'(acc_status), 32'h12);
    drv(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
    step();
    chk("pre_rst_level", 32'(level), 32'd3);

    // Asynchronous reset mid-stream
    drv(1'b1, 32'h11111111, 8'h01, 1'b1, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_acc", 32'(acc_status), 32'd0);
    chk("arst_drop", 32'(drop_cnt), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    chk("hold_level", 32'(level), 32'd0);
    rst = 1'b1;
    drv(1'b1, 32'h22222222, 8'h08, 1'b0, 1'b0);
    step();
    chk("rel_level", 32'(level), 32'd1);
    chk("rel_z", bus.out_z, 32'h22222222);
    chk("rel_acc", 32'(acc_status), 32'h08);

    // Streaming push+pop keeps level, pointers wrap
    for (int i = 0; i < 10; i++) begin
      drv(1'b1, 32'h50000000 + i, 8'h00, 1'b1, 1'b0);
      step();
    end
    chk("stream_level", 32'(level), 32'd1);
    chk("stream_z", bus.out_z, 32'h50000009);
    drv(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
    repeat (2) step();
    chk("end_level", 32'(level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
